// File: rtl/puf_auth_scheduler_pkg.sv
// puf_auth_scheduler_pkg: shared state encoding, LFSR constants and parameter defaults
package puf_auth_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, ARB, LOAD, START, WAIT, RESULT} state_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_MAX_RETRY = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_LOCK_THRESH = 3;
endpackage

// File: rtl/puf_auth_scheduler_rr_arbiter_onehot.sv
// rr_arbiter_onehot: round-robin one-hot arbiter whose search starts after the last winner
import puf_auth_scheduler_pkg::*;
module rr_arbiter_onehot #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_masked,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_onehot
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic found;
  always_comb begin
    grant_onehot = '0;
    ptr_d = ptr_q;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_masked[idx]) begin
        found = 1'b1;
        grant_onehot[idx] = 1'b1;
        ptr_d = PW'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else if (advance) ptr_q <= ptr_d;
endmodule

// File: rtl/puf_auth_scheduler.sv
// puf_auth_scheduler: arbitrates chiplet PUF authentication requests onto one engine,
// with watchdog retries and sticky per-port tamper lockout.
import puf_auth_scheduler_pkg::*;
module puf_auth_scheduler #(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int MAX_RETRY   = DEF_MAX_RETRY,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [15:0]        req_n_base,
  input  logic [15:0]        req_l_scan,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] pass,
  output logic [NUM_REQ-1:0] locked,
  output logic               eng_start,
  output logic [15:0]        eng_n_auth,
  output logic [15:0]        eng_l_scan,
  input  logic               eng_success,
  input  logic               eng_tamper,
  output logic               busy
);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, locked_q, arb_grant;
  logic [15:0] lfsr_q, n_auth_q, l_scan_q;
  logic [31:0] wd_q, wd_d, retry_q, retry_d;
  logic pass_q, pass_d, tamp_q, tamp_d;
  logic [7:0] tcnt_q [NUM_REQ];

  rr_arbiter_onehot #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req_masked(req & ~locked_q),
    .advance(state_q == ARB),
    .grant_onehot(arb_grant)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wd_d = wd_q;
    retry_d = retry_q;
    pass_d = pass_q;
    tamp_d = tamp_q;
    case (state_q)
      IDLE: state_d = |(req & ~locked_q) ? ARB : IDLE;
      ARB: begin
        grant_d = arb_grant;
        state_d = |arb_grant ? LOAD : IDLE;
      end
      LOAD: state_d = START;
      START: begin
        wd_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 32'd1;
        if (eng_tamper) begin
          state_d = RESULT;
          pass_d = 1'b0;
          tamp_d = 1'b1;
        end else if (eng_success) begin
          state_d = RESULT;
          pass_d = 1'b1;
          tamp_d = 1'b0;
        end else if (wd_q == 32'(TIMEOUT_CYC - 1)) begin
          // a timeout fails without counting as tamper
          if (retry_q < 32'(MAX_RETRY)) begin
            retry_d = retry_q + 32'd1;
            state_d = LOAD;
          end else begin
            state_d = RESULT;
            pass_d = 1'b0;
            tamp_d = 1'b0;
          end
        end
      end
      RESULT: begin
        grant_d = '0;
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      wd_q <= '0;
      retry_q <= '0;
      pass_q <= 1'b0;
      tamp_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      n_auth_q <= '0;
      l_scan_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wd_q <= wd_d;
      retry_q <= retry_d;
      pass_q <= pass_d;
      tamp_q <= tamp_d;
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      if (state_q == LOAD) begin
        n_auth_q <= req_n_base + {12'b0, lfsr_q[3:0]};
        l_scan_q <= req_l_scan;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      locked_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) tcnt_q[i] <= '0;
    end else if (state_q == RESULT) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant_q[i]) begin
          if (pass_q) tcnt_q[i] <= '0;
          else if (tamp_q && tcnt_q[i] != 8'(LOCK_THRESH)) begin
            tcnt_q[i] <= tcnt_q[i] + 8'd1;
            if (tcnt_q[i] + 8'd1 == 8'(LOCK_THRESH)) locked_q[i] <= 1'b1;
          end
        end
    end

  assign grant = grant_q;
  assign done = state_q == RESULT ? grant_q : '0;
  assign pass = (state_q == RESULT && pass_q) ? grant_q : '0;
  assign locked = locked_q;
  assign eng_start = state_q == START;
  assign eng_n_auth = n_auth_q;
  assign eng_l_scan = l_scan_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_puf_auth_scheduler.sv
// tb_puf_auth_scheduler: vector table, hand-written corner sequences and a randomized
// run against a behavioural scoreboard of arbitration, tamper counting and lockout.
module tb_puf_auth_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, req2;
  logic [15:0] base, lscan;
  logic succ, tamp;
  logic [3:0] grant, done, pass, locked, grant2, done2, pass2, locked2;
  logic eng_start, busy, eng_start2, busy2;
  logic [15:0] n_auth, l_scan, n_auth2, l_scan2;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  puf_auth_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_n_base(base), .req_l_scan(lscan),
    .grant(grant), .done(done), .pass(pass), .locked(locked), .eng_start(eng_start),
    .eng_n_auth(n_auth), .eng_l_scan(l_scan), .eng_success(succ), .eng_tamper(tamp),
    .busy(busy)
  );

  puf_auth_scheduler #(.TIMEOUT_CYC(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_n_base(16'd7), .req_l_scan(16'd3),
    .grant(grant2), .done(done2), .pass(pass2), .locked(locked2), .eng_start(eng_start2),
    .eng_n_auth(n_auth2), .eng_l_scan(l_scan2), .eng_success(1'b0), .eng_tamper(1'b0),
    .busy(busy2)
  );

  typedef struct {
    logic [3:0] req;
    logic [15:0] base, lscan;
    int d;
    bit s, t;
    logic [3:0] eg, ep, el;
  } vec_t;
  vec_t tbl[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    req2 = '0;
    succ = 1'b0;
    tamp = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // serve one session: answer d cycles after eng_start with (s,t), then step past done
  task automatic session(input int d, input bit s, input bit t, output logic [3:0] g,
                         output logic [3:0] dn, output logic [3:0] ps,
                         output logic [15:0] na, output logic [15:0] ls, output int lat);
    lat = 0;
    while (!eng_start && lat < 10) begin
      tick;
      lat++;
    end
    chk("start_seen", 32'(eng_start), 1);
    g = grant;
    na = n_auth;
    ls = l_scan;
    repeat (d) tick;
    succ = s;
    tamp = t;
    tick;
    succ = 1'b0;
    tamp = 1'b0;
    dn = done;
    ps = pass;
    tick;
    chk("done_one_shot", 32'(done), 0);
  endtask

  logic [3:0] g, dn, ps, ml, act, r;
  logic [15:0] na, ls;
  int lat, last, p, o, d;
  int tc[4];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b1111, 16'd100,    16'd5, 3,  1, 0, 4'b0001, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b1111, 16'hFFF8,   16'd6, 1,  1, 0, 4'b0010, 4'b0010, 4'b0000};
    tbl[2]  = '{4'b1111, 16'd0,      16'd7, 7,  1, 0, 4'b0100, 4'b0100, 4'b0000};
    tbl[3]  = '{4'b1111, 16'd500,    16'd9, 2,  1, 0, 4'b1000, 4'b1000, 4'b0000};
    tbl[4]  = '{4'b1111, 16'd1,      16'd1, 4,  1, 0, 4'b0001, 4'b0001, 4'b0000};
    tbl[5]  = '{4'b0001, 16'd20,     16'd8, 40, 1, 0, 4'b0001, 4'b0001, 4'b0000};
    tbl[6]  = '{4'b0100, 16'd30,     16'd2, 5,  0, 1, 4'b0100, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0100, 16'd30,     16'd2, 5,  0, 1, 4'b0100, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0100, 16'd30,     16'd2, 5,  0, 1, 4'b0100, 4'b0000, 4'b0100};
    tbl[9]  = '{4'b0010, 16'd40,     16'd4, 2,  1, 1, 4'b0010, 4'b0000, 4'b0100};
    tbl[10] = '{4'b0010, 16'd40,     16'd4, 3,  0, 1, 4'b0010, 4'b0000, 4'b0100};
    tbl[11] = '{4'b0010, 16'd40,     16'd4, 1,  0, 1, 4'b0010, 4'b0000, 4'b0110};

    rst_n = 1'b0;
    req = '0;
    req2 = '0;
    base = '0;
    lscan = '0;
    succ = 1'b0;
    tamp = 1'b0;
    tick;
    chk("reset_outputs", {grant, done, pass, locked, 3'b0, eng_start, 3'b0, busy, 8'b0}, 0);
    chk("reset_engine_args", {n_auth, l_scan}, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      base = tbl[i].base;
      lscan = tbl[i].lscan;
      session(tbl[i].d, tbl[i].s, tbl[i].t, g, dn, ps, na, ls, lat);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_grant", i), 32'(g), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_done", i), 32'(dn), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_pass", i), 32'(ps), 32'(tbl[i].ep));
      chk($sformatf("vec%0d_n_auth_range", i), 32'(16'(na - tbl[i].base) <= 16'd15), 1);
      chk($sformatf("vec%0d_l_scan", i), 32'(ls), 32'(tbl[i].lscan));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].el));
    end

    req = 4'b0100;
    repeat (10) tick;
    chk("locked_req_ignored", 32'(busy), 0);

    // abandon a WAIT with reset; port 0 wins afterwards even though the pointer had moved on
    req = 4'b0001;
    lat = 0;
    while (!eng_start && lat < 10) begin
      tick;
      lat++;
    end
    repeat (3) tick;
    chk("busy_before_reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {grant, done, pass, locked, 3'b0, eng_start, 3'b0, busy, 8'b0}, 0);
    chk("async_reset_engine_args", {n_auth, l_scan}, 0);
    req = 4'b1001;
    tick;
    chk("in_reset_no_done", 32'(done), 0);
    rst_n = 1'b1;
    session(2, 1, 0, g, dn, ps, na, ls, lat);
    chk("post_reset_grant", 32'(g), 1);
    chk("post_reset_pass", 32'(ps), 1);
    req = '0;

    for (int it = 0; it < 45; it++) begin
      if (it % 15 == 0) begin
        do_reset;
        last = 3;
        ml = '0;
        foreach (tc[k]) tc[k] = 0;
      end
      r = 4'($urandom_range(1, 15));
      act = r & ~ml;
      req = r;
      base = 16'($urandom);
      lscan = 16'($urandom);
      if (act == 0) begin
        repeat (4) tick;
        chk("rand_ignored_busy", 32'(busy), 0);
      end else begin
        p = -1;
        for (int k = 1; k <= 4 && p < 0; k++)
          if (act[(last + k) % 4]) p = (last + k) % 4;
        o = $urandom_range(0, 2);
        d = $urandom_range(1, 20);
        session(d, o != 1, o != 0, g, dn, ps, na, ls, lat);
        last = p;
        if (o == 0) tc[p] = 0;
        else if (tc[p] < 3) tc[p]++;
        if (tc[p] == 3) ml[p] = 1'b1;
        chk("rand_grant", 32'(g), 32'(1 << p));
        chk("rand_done", 32'(dn), 32'(1 << p));
        chk("rand_pass", 32'(ps), o == 0 ? 32'(1 << p) : 0);
        chk("rand_n_auth_range", 32'(16'(na - base) <= 16'd15), 1);
        chk("rand_locked", 32'(locked), 32'(ml));
      end
    end
    req = '0;

    begin
      int st[3];
      int ns, dt;
      logic [3:0] dn2, ps2;
      ns = 0;
      dt = -1;
      dn2 = '0;
      ps2 = '0;
      st = '{0, 0, 0};
      tick;
      req2 = 4'b0001;
      for (int c = 1; c <= 120 && dt < 0; c++) begin
        tick;
        if (eng_start2) begin
          if (ns < 3) st[ns] = c;
          ns++;
        end
        if (done2 != 0) begin
          dt = c;
          dn2 = done2;
          ps2 = pass2;
          req2 = '0;
        end
      end
      chk("to_start_count", ns, 3);
      chk("to_first_latency", st[0], 3);
      chk("to_retry1_gap", st[1] - st[0], 18);
      chk("to_retry2_gap", st[2] - st[1], 18);
      chk("to_done_gap", dt - st[2], 17);
      chk("to_done", 32'(dn2), 1);
      chk("to_pass", 32'(ps2), 0);
      tick;
      chk("to_locked", 32'(locked2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/puf_auth_scheduler.md
PUF_AUTH_SCHEDULER -- requirements
Module: puf_auth_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesting chiplet ports.
REQ-002 Parameter MAX_RETRY, default 2: re-runs allowed after a timeout.
REQ-003 Parameter TIMEOUT_CYC, default 1024: per-run watchdog limit in cycles.
REQ-004 Parameter LOCK_THRESH, default 3: consecutive tamper results before a port is locked.
REQ-005 Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-port authentication request (level).
- req_n_base  in  16  minimum intermediate-dummy count.
- req_l_scan  in  16  scan length for all runs.
- grant  out  NUM_REQ  one-hot, the port currently served.
- done  out  NUM_REQ  one-cycle completion pulse.
- pass  out  NUM_REQ  result, valid with done.
- locked  out  NUM_REQ  sticky port lockout.
- eng_start  out  1  one-cycle engine start pulse.
- eng_n_auth  out  16  engine dummy count.
- eng_l_scan  out  16  engine scan length.
- eng_success  in  1  engine pass indication.
- eng_tamper  in  1  engine tamper indication.
- busy  out  1  session in progress.

Function
REQ-006 States: IDLE, ARB, LOAD, START, WAIT, RESULT.
REQ-007 IDLE: go to ARB when any bit of (req & ~locked) is high; otherwise stay.
REQ-008 ARB: round-robin over (req & ~locked), starting at the port after the last granted port; port 0 has priority after reset. Register the one-hot grant, then go to LOAD.
REQ-009 Hold grant from ARB exit until the RESULT exit; it is all-zero otherwise.
REQ-010 LOAD: latch eng_n_auth = req_n_base + {12'b0, lfsr[3:0]} (16-bit, wrapping) and eng_l_scan = req_l_scan, then go to START.
REQ-011 Hold eng_n_auth and eng_l_scan stable from LOAD until the next LOAD.
REQ-012 LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset seed 16'hACE1. It advances every cycle, regardless of state.
REQ-013 START: assert eng_start for exactly one cycle, clear the watchdog, then go to WAIT.
REQ-014 WAIT: the watchdog increments each cycle. If eng_tamper, go to RESULT with outcome FAIL. Otherwise, if eng_success, go to RESULT with outcome PASS. Tamper wins if both are high in the same cycle.
REQ-015 WAIT timeout: when the watchdog reaches TIMEOUT_CYC-1 with neither input high:
- if retry count < MAX_RETRY, increment the retry count and go to LOAD, which re-draws eng_n_auth;
- else go to RESULT with outcome FAIL.
A timeout does not change the tamper count.
REQ-016 RESULT (one cycle): pulse done[granted] and drive pass[granted] = (outcome==PASS). Update the granted port's tamper count: PASS clears it; tamper-FAIL increments it, saturating at LOCK_THRESH. Set locked[granted] when the count reaches LOCK_THRESH. Clear the retry count and go to IDLE.
REQ-017 pass and done are zero for all non-granted ports every cycle; pass is zero when done is low.
REQ-018 A requester deasserting req mid-session does not abort the session; done still pulses.
REQ-019 locked bits are cleared only by reset. While locked, a port's req is ignored.
REQ-020 busy = (state != IDLE).
REQ-021 Latency, no retry: request seen in IDLE -> eng_start three cycles later (ARB, LOAD, START).

Reset
REQ-022 On rst_n low, immediately and asynchronously:
- state = IDLE;
- grant, done, pass, locked, eng_start, busy = 0;
- eng_n_auth, eng_l_scan = 0;
- watchdog, retry count, tamper counts = 0;
- round-robin pointer = port 0;
- LFSR = 16'hACE1.
REQ-023 Reset mid-session abandons the run with no done pulse. Engine inputs are ignored until the next START.

Structure
REQ-024 Shared package holds the state encoding, the LFSR seed/taps constants, and the default values of NUM_REQ, MAX_RETRY, TIMEOUT_CYC and LOCK_THRESH.
REQ-025 The round-robin arbiter is a separate sub-module, rr_arbiter_onehot, parameterised by NUM_REQ, with inputs req_masked and advance and output grant_onehot.

Verification
REQ-026 Single pass: req=4'b0001, base=16'd20, l_scan=16'd8, eng_success 40 cycles after eng_start -> eng_n_auth in [20,35], done[0]=1 with pass[0]=1, locked=0.
REQ-027 Fairness: req=4'b1111 held, engine always passes -> grants cycle in the order 0,1,2,3,0, one done per session.
REQ-028 Lockout: port 2 alone gets eng_tamper on three consecutive sessions -> pass[2]=0 each time, locked[2]=1 after the third, and later req[2] is ignored (busy stays 0).
REQ-029 Timeout and retry: engine silent, TIMEOUT_CYC=16 -> three eng_start pulses, 16 cycles apart plus the LOAD/START overhead, then done with pass=0, locked unchanged.
REQ-030 Simultaneous success and tamper in WAIT -> pass=0 and the tamper count increments.
REQ-031 rst_n asserted during WAIT -> all outputs 0 at once. After release, a new req restarts at ARB with port 0 priority.
